imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Program-mode loader that owns the instruction-memory write port while the system is in program_mode.
- Accepts a byte stream from the host interface (UART receiver) over a valid/ready handshake and assembles byte pairs into 16-bit instruction words.
- Writes each word to consecutive imem addresses starting at 0.
- Holds the multicycle CPU controller in reset for the whole load, then releases it so execution starts from BOOT with the new program.

Parameters:
- INSTR_WIDTH, 16, instruction word width; fixed at 2 bytes, opcode in bits [15:12].
- ADDR_WIDTH, 8, imem address width; depth = 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- program_mode  input  1  level; high = loading allowed.
- in_data  input  8  byte from host interface.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte; byte consumed on clk edge where in_valid & in_ready.
- imem_write  output  1  one-cycle write strobe to imem.
- imem_addr  output  ADDR_WIDTH  write address.
- imem_wdata  output  INSTR_WIDTH  write data.
- cpu_reset  output  1  held high while loading; OR'd into the control/datapath reset at top level.
- busy  output  1  high in any state other than IDLE.
- word_count  output  ADDR_WIDTH+1  words written since load start.
- overflow  output  1  sticky; memory filled and extra bytes received.

Behaviour:
- All outputs registered.
- Reset values:
  - in_ready=0, imem_write=0, imem_addr=0, imem_wdata=0, cpu_reset=0, busy=0, word_count=0, overflow=0.
  - State = IDLE, byte holding register = 0.
- States: IDLE, HI_BYTE, LO_BYTE, WRITE, FULL, RELEASE.
- IDLE:
  - in_ready=0, cpu_reset=0.
  - program_mode=1 -> HI_BYTE; on entry clear imem_addr, word_count, overflow, and set cpu_reset=1.
- HI_BYTE:
  - in_ready=1.
  - Accepted byte is stored as the word's bits [15:8] (opcode byte first) -> LO_BYTE.
- LO_BYTE:
  - in_ready=1.
  - Accepted byte forms bits [7:0]; imem_wdata loaded -> WRITE.
- WRITE:
  - Exactly one cycle: imem_write=1, in_ready=0.
  - Next cycle: imem_write=0, word_count+1.
  - If imem_addr = 2**ADDR_WIDTH-1 -> FULL with imem_addr unchanged; else imem_addr+1 -> HI_BYTE.
- Latency: second byte accepted on edge N; imem_write is high during cycle N+1.
- FULL:
  - in_ready=1; bytes are accepted and discarded.
  - The first discarded byte sets overflow=1 (sticky until the next load start).
  - No further imem_write.
- program_mode falling:
  - In HI_BYTE, LO_BYTE or FULL: go to RELEASE on the next edge. A half-assembled word (high byte only) is discarded, not written.
  - In WRITE: the write completes, then RELEASE.
  - A handshake in the same cycle as program_mode=0 is not accepted: in_ready drops combinationally with program_mode.
- RELEASE:
  - cpu_reset=1, in_ready=0 for one cycle, then IDLE with cpu_reset=0.
  - This guarantees the CPU sees at least one reset cycle after the last imem_write.
- program_mode re-asserted in RELEASE: goes to IDLE first, then starts a new load (addresses restart at 0).
- word_count saturates at 2**ADDR_WIDTH; it never wraps.
- imem_addr never wraps during one load.
- reset asserted mid-load: immediate return to reset values. No imem_write in the reset cycle. The partial word is lost.
- in_valid while in IDLE/WRITE/RELEASE: ignored (in_ready=0); the source must hold the byte.

Test Plan:
- program_mode=1, bytes 0x51,0x23,0x70,0x04 with continuous in_valid, then program_mode=0 -> imem writes 0x5123@0 and 0x7004@1; each imem_write is one cycle, one cycle after the low byte; word_count=2; cpu_reset high from load start through the RELEASE cycle, then 0.
- Same stream with in_valid gapped 3 cycles between bytes -> identical writes; in_ready stays high while waiting; no extra strobes.
- program_mode=1, bytes 0xAB,0xCD,0xEF, then program_mode=0 -> only 0xABCD@0 written; 0xEF dropped; word_count=1.
- ADDR_WIDTH=2: send 10 bytes -> 4 writes @0..3, FULL reached, overflow=1, imem_addr=3, word_count=4, no 5th strobe.
- reset pulse for 1 cycle after high byte 0x12 -> all outputs return to reset values; new load of 0x34,0x56 writes 0x3456@0.
- in_valid=1 in the cycle program_mode falls with in_ready=0 -> byte not consumed; RELEASE lasts exactly 1 cycle, then IDLE.

Source files
------------

// File: rtl/imem_loader.sv
// Program-mode loader: assembles host bytes into 16-bit words, writes them to imem
// from address 0 and holds the CPU in reset until the load finishes.
module imem_loader #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   program_mode,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   imem_write,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   cpu_reset,
    output logic                   busy,
    output logic [ADDR_WIDTH:0]    word_count,
    output logic                   overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI_BYTE,
        S_LO_BYTE,
        S_WRITE,
        S_FULL,
        S_RELEASE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_WIDTH:0]   COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                   state_q, state_d;
    logic [7:0]               hi_q, hi_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [INSTR_WIDTH-1:0]   wdata_q, wdata_d;
    logic [ADDR_WIDTH:0]      count_q, count_d;
    logic                     ovf_q, ovf_d;
    logic                     rdy_q, rdy_d;
    logic                     wr_q, wr_d;
    logic                     busy_q, busy_d;
    logic                     cpu_rst_q, cpu_rst_d;
    logic                     accept;

    // Ready is gated by program_mode so no byte is taken in the cycle the mode drops.
    assign in_ready = rdy_q & program_mode;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (program_mode) begin
                    state_d = S_HI_BYTE;
                    addr_d  = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_HI_BYTE: begin
                if (!program_mode) begin
                    state_d = S_RELEASE;
                end else if (accept) begin
                    hi_d    = in_data;
                    state_d = S_LO_BYTE;
                end
            end
            S_LO_BYTE: begin
                if (!program_mode) begin
                    state_d = S_RELEASE;
                end else if (accept) begin
                    wdata_d = {hi_q, in_data};
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (count_q != COUNT_MAX) begin
                    count_d = count_q + 1'b1;
                end
                if (addr_q == ADDR_LAST) begin
                    state_d = program_mode ? S_FULL : S_RELEASE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = program_mode ? S_HI_BYTE : S_RELEASE;
                end
            end
            S_FULL: begin
                if (!program_mode) begin
                    state_d = S_RELEASE;
                end else if (accept) begin
                    ovf_d = 1'b1;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Output flags are registered copies decoded from the next state.
        rdy_d     = (state_d == S_HI_BYTE) || (state_d == S_LO_BYTE) || (state_d == S_FULL);
        wr_d      = (state_d == S_WRITE);
        busy_d    = (state_d != S_IDLE);
        cpu_rst_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            rdy_q     <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            cpu_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            rdy_q     <= rdy_d;
            wr_q      <= wr_d;
            busy_q    <= busy_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    assign imem_write = wr_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_reset  = cpu_rst_q;
    assign busy       = busy_q;
    assign word_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-size instance plus a 4-word instance
// sharing the same stimulus, used to exercise the full-memory path.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        program_mode;
    logic [7:0]  in_data;
    logic        in_valid;

    logic        in_ready, imem_write, cpu_reset, busy, overflow;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic [8:0]  word_count;

    logic        s_in_ready, s_imem_write, s_cpu_reset, s_busy, s_overflow;
    logic [1:0]  s_imem_addr;
    logic [15:0] s_imem_wdata;
    logic [2:0]  s_word_count;

    imem_loader #(.INSTR_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .program_mode(program_mode),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .imem_write(imem_write), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .word_count(word_count), .overflow(overflow)
    );

    imem_loader #(.INSTR_WIDTH(16), .ADDR_WIDTH(2)) dut_s (
        .clk(clk), .reset(reset), .program_mode(program_mode),
        .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
        .imem_write(s_imem_write), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
        .cpu_reset(s_cpu_reset), .busy(s_busy), .word_count(s_word_count), .overflow(s_overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write logs for both instances, sampled on the falling edge.
    logic [7:0]  wr_addr [16];
    logic [15:0] wr_data [16];
    int          wr_cyc  [16];
    int          wr_n = 0;
    int          dbl  = 0;
    bit          prev_wr = 0;
    logic [1:0]  ws_addr [16];
    logic [15:0] ws_data [16];
    int          ws_n = 0;
    int          s_dbl = 0;
    bit          prev_ws = 0;

    int          lo_cyc [16];
    int          lo_n = 0;
    int          acc_cyc = 0;

    always @(negedge clk) begin
        if (imem_write) begin
            if (wr_n < 16) begin
                wr_addr[wr_n] = imem_addr;
                wr_data[wr_n] = imem_wdata;
                wr_cyc[wr_n]  = cyc;
            end
            wr_n++;
            if (prev_wr) dbl++;
        end
        prev_wr = imem_write;
        if (s_imem_write) begin
            if (ws_n < 16) begin
                ws_addr[ws_n] = s_imem_addr;
                ws_data[ws_n] = s_imem_wdata;
            end
            ws_n++;
            if (prev_ws) s_dbl++;
        end
        prev_ws = s_imem_write;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check_val("handshake", {31'd0, ok}, 32'd1);
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(negedge clk);
            check_val("rdy_wait", {31'd0, in_ready}, 32'd1);
        end
    endtask

    task automatic send_word(input logic [7:0] hi, input logic [7:0] lo, input int gap);
        send_byte(hi, gap);
        send_byte(lo, gap);
        if (lo_n < 16) lo_cyc[lo_n] = acc_cyc;
        lo_n++;
    endtask

    task automatic begin_load();
        wr_n = 0;
        ws_n = 0;
        lo_n = 0;
        program_mode = 1'b1;
    endtask

    task automatic finish_load();
        program_mode = 1'b0;
        @(negedge clk);
        check_val("rel_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check_val("rel_busy", {31'd0, busy}, 32'd1);
        check_val("rel_ready", {31'd0, in_ready}, 32'd0);
        check_val("rel_write", {31'd0, imem_write}, 32'd0);
        @(negedge clk);
        check_val("idle_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check_val("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        program_mode = 1'b0;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_ready", {31'd0, in_ready}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check_val("rst_count", {23'd0, word_count}, 32'd0);
        check_val("rst_wdata", {16'd0, imem_wdata}, 32'd0);

        // Continuous stream of two words.
        begin_load();
        @(negedge clk);
        check_val("t1_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check_val("t1_ready", {31'd0, in_ready}, 32'd1);
        send_word(8'h51, 8'h23, 0);
        send_word(8'h70, 8'h04, 0);
        finish_load();
        check_val("t1_nwr", wr_n, 2);
        check_val("t1_a0", {24'd0, wr_addr[0]}, 32'h0);
        check_val("t1_d0", {16'd0, wr_data[0]}, 32'h5123);
        check_val("t1_a1", {24'd0, wr_addr[1]}, 32'h1);
        check_val("t1_d1", {16'd0, wr_data[1]}, 32'h7004);
        check_val("t1_lat0", wr_cyc[0], lo_cyc[0]);
        check_val("t1_lat1", wr_cyc[1], lo_cyc[1]);
        check_val("t1_count", {23'd0, word_count}, 32'd2);

        // Same stream with 3-cycle gaps between bytes.
        begin_load();
        send_word(8'h51, 8'h23, 3);
        send_word(8'h70, 8'h04, 3);
        finish_load();
        check_val("t2_nwr", wr_n, 2);
        check_val("t2_d0", {16'd0, wr_data[0]}, 32'h5123);
        check_val("t2_d1", {16'd0, wr_data[1]}, 32'h7004);
        check_val("t2_a1", {24'd0, wr_addr[1]}, 32'h1);
        check_val("t2_lat1", wr_cyc[1], lo_cyc[1]);
        check_val("t2_count", {23'd0, word_count}, 32'd2);

        // Odd byte count: trailing high byte dropped.
        begin_load();
        send_word(8'hAB, 8'hCD, 0);
        send_byte(8'hEF, 0);
        finish_load();
        check_val("t3_nwr", wr_n, 1);
        check_val("t3_d0", {16'd0, wr_data[0]}, 32'hABCD);
        check_val("t3_a0", {24'd0, wr_addr[0]}, 32'h0);
        check_val("t3_count", {23'd0, word_count}, 32'd1);

        // Ten bytes into the 4-word instance: fills, then overflows.
        begin_load();
        for (int i = 0; i < 10; i++) send_byte(8'h10 + 8'(i), 0);
        check_val("t4_s_nwr", ws_n, 4);
        check_val("t4_s_d0", {16'd0, ws_data[0]}, 32'h1011);
        check_val("t4_s_d3", {16'd0, ws_data[3]}, 32'h1617);
        check_val("t4_s_a3", {30'd0, ws_addr[3]}, 32'd3);
        check_val("t4_s_addr", {30'd0, s_imem_addr}, 32'd3);
        check_val("t4_s_count", {29'd0, s_word_count}, 32'd4);
        check_val("t4_s_ovf", {31'd0, s_overflow}, 32'd1);
        check_val("t4_s_ready", {31'd0, s_in_ready}, 32'd1);
        check_val("t4_big_ovf", {31'd0, overflow}, 32'd0);
        finish_load();
        check_val("t4_s_nwr_end", ws_n, 4);
        check_val("t4_s_count_end", {29'd0, s_word_count}, 32'd4);

        // Reset pulse after a lone high byte, then a fresh load.
        begin_load();
        send_byte(8'h12, 0);
        reset = 1'b1;
        @(negedge clk);
        check_val("t5_ready", {31'd0, in_ready}, 32'd0);
        check_val("t5_write", {31'd0, imem_write}, 32'd0);
        check_val("t5_addr", {24'd0, imem_addr}, 32'd0);
        check_val("t5_wdata", {16'd0, imem_wdata}, 32'd0);
        check_val("t5_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check_val("t5_busy", {31'd0, busy}, 32'd0);
        check_val("t5_count", {23'd0, word_count}, 32'd0);
        check_val("t5_s_ovf", {31'd0, s_overflow}, 32'd0);
        reset = 1'b0;
        send_word(8'h34, 8'h56, 0);
        finish_load();
        check_val("t5_nwr", wr_n, 1);
        check_val("t5_d0", {16'd0, wr_data[0]}, 32'h3456);
        check_val("t5_a0", {24'd0, wr_addr[0]}, 32'h0);

        // program_mode drops in the same cycle as in_valid rises.
        begin_load();
        @(negedge clk);
        check_val("t6_ready_pre", {31'd0, in_ready}, 32'd1);
        in_data      = 8'h99;
        in_valid     = 1'b1;
        program_mode = 1'b0;
        #1;
        check_val("t6_ready_drop", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check_val("t6_rel_busy", {31'd0, busy}, 32'd1);
        check_val("t6_rel_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check_val("t6_rel_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check_val("t6_idle_busy", {31'd0, busy}, 32'd0);
        check_val("t6_idle_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        in_valid = 1'b0;
        check_val("t6_nwr", wr_n, 0);

        check_val("dbl_strobe", dbl, 0);
        check_val("s_dbl_strobe", s_dbl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
